// File: rtl/main_memory_2a_if.sv
// Block-level request/response bundle between the cache controller and main memory.
// Latency: n/a (wires only).
// Backpressure: master may only launch a request while busy is low; memReady marks completion.
interface main_memory_2a_if;
    logic         memRequest;
    logic         readWrite;
    logic [9:0]   memAddr;
    logic [127:0] writeDataMem;
    logic         busy;
    logic         memReady;
    logic [127:0] readDataMem;

    modport master (
        output memRequest, readWrite, memAddr, writeDataMem,
        input  busy, memReady, readDataMem
    );

    modport slave (
        input  memRequest, readWrite, memAddr, writeDataMem,
        output busy, memReady, readDataMem
    );
endinterface

// File: rtl/main_memory_2a.sv
// Block-granular main memory: one 128-bit (4-word) block read or written per request.
// Latency: accept at edge k, memReady pulses in the cycle after edge k+LATENCY.
// Backpressure: requests are ignored while busy; one request per LATENCY+2 cycles at most.
module main_memory_2a #(
    parameter int LATENCY   = 4,
    parameter int NUM_WORDS = 256
) (
    input  logic            clock,
    input  logic            reset,
    main_memory_2a_if.slave bus
);
    localparam int         AW       = $clog2(NUM_WORDS);
    localparam int         BW       = AW - 2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic            rw_q;
    logic [BW-1:0]   blk_q;
    logic [127:0]    wdat_q;
    logic            busy_q;
    logic            ready_q;
    logic [127:0]    rdat_q;

    logic [31:0]     rd_word [NUM_WORDS];
    logic [127:0]    rd_block;
    logic            commit_wr;
    logic [3:0]      unused_addr_lsb;

    // Byte offset inside a block carries no meaning for block transfers.
    assign unused_addr_lsb = bus.memAddr[3:0];

    // A write lands exactly on the WAIT->DONE edge; a reset in that cycle cancels it.
    assign commit_wr = !reset && (state_q == ST_WAIT) && (cnt_q == 4'd0) && rw_q;

    assign rd_block = {rd_word[{blk_q, 2'd3}], rd_word[{blk_q, 2'd2}],
                       rd_word[{blk_q, 2'd1}], rd_word[{blk_q, 2'd0}]};

    // Storage: each word starts out holding its own index and is never cleared by reset.
    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
        logic [31:0] word_q = 32'(g);

        // Update this word from its lane of the latched block when its block is committed.
        always_ff @(posedge clock) begin
            if (commit_wr && (blk_q == BW'(g >> 2))) begin
                word_q <= wdat_q[32*(g % 4) +: 32];
            end
        end

        assign rd_word[g] = word_q;
    end

    // Request FSM: latch the request in IDLE, count down in WAIT, pulse memReady in DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            blk_q   <= '0;
            wdat_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            rdat_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.memRequest) begin
                        rw_q    <= bus.readWrite;
                        blk_q   <= bus.memAddr[4 +: BW];
                        wdat_q  <= bus.writeDataMem;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (!rw_q) begin
                            rdat_q <= rd_block;
                        end
                        ready_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.memReady    = ready_q;
    assign bus.readDataMem = rdat_q;
endmodule

// File: tb/tb_main_memory_2a.sv
// Scoreboard bench for main_memory_2a with two instances (LATENCY 4 and 1).
// Expected responses are queued at request acceptance from a word-array model.
// A negedge monitor pops and compares whenever memReady is seen.
module tb_main_memory_2a;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    main_memory_2a_if if4 ();
    main_memory_2a_if if1 ();

    main_memory_2a #(.LATENCY(4), .NUM_WORDS(256)) u_lat4 (.clock(clock), .reset(reset), .bus(if4));
    main_memory_2a #(.LATENCY(1), .NUM_WORDS(256)) u_lat1 (.clock(clock), .reset(reset), .bus(if1));

    logic         req  [2];
    logic         rw   [2];
    logic [9:0]   addr [2];
    logic [127:0] wdat [2];
    logic         busy [2];
    logic         rdy  [2];
    logic [127:0] rdat [2];

    assign if4.memRequest   = req[0];
    assign if4.readWrite    = rw[0];
    assign if4.memAddr      = addr[0];
    assign if4.writeDataMem = wdat[0];
    assign busy[0]          = if4.busy;
    assign rdy[0]           = if4.memReady;
    assign rdat[0]          = if4.readDataMem;

    assign if1.memRequest   = req[1];
    assign if1.readWrite    = rw[1];
    assign if1.memAddr      = addr[1];
    assign if1.writeDataMem = wdat[1];
    assign busy[1]          = if1.busy;
    assign rdy[1]           = if1.memReady;
    assign rdat[1]          = if1.readDataMem;

    typedef struct {
        bit         is_wr;
        bit [127:0] blk;
        int         acc;
    } exp_t;

    bit [31:0]  mdl [2][256];
    bit [127:0] last_rd [2];
    exp_t       q0[$];
    exp_t       q1[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int lat(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic bit [127:0] model_blk(int d, bit [9:0] a);
        int b;
        b = int'(a[9:4]);
        return {mdl[d][b*4+3], mdl[d][b*4+2], mdl[d][b*4+1], mdl[d][b*4]};
    endfunction

    task automatic check(string name, int d, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h, want %h", name, d, act, exp);
        end
    endtask

    task automatic push_exp(int d, exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: every memReady pulse must match exactly one queued expectation.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            bit   got;
            got = 1'b0;
            if (!reset && rdy[d] === 1'b1) begin
                if (d == 0 && q0.size() > 0) begin
                    e = q0.pop_front(); got = 1'b1;
                end else if (d == 1 && q1.size() > 0) begin
                    e = q1.pop_front(); got = 1'b1;
                end
                if (!got) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_memReady dut%0d: got a pulse, want none", d);
                end else begin
                    check("ready_latency", d, 128'(cyc - e.acc), 128'(lat(d)));
                    check("busy_at_ready", d, 128'(busy[d]), 128'd1);
                    if (!e.is_wr) last_rd[d] = e.blk;
                    check(e.is_wr ? "rdata_hold_on_write" : "read_data", d, rdat[d], last_rd[d]);
                end
            end
        end
    end

    task automatic wait_idle(int d);
        int t;
        t = 0;
        @(negedge clock);
        while (busy[d] !== 1'b0 && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (busy[d] !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout dut%0d: busy=%b, want 0", d, busy[d]);
        end
    endtask

    task automatic wait_drain(int d);
        int t;
        t = 0;
        while (((d == 0) ? q0.size() : q1.size()) != 0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (((d == 0) ? q0.size() : q1.size()) != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout dut%0d: pending=%0d, want 0", d,
                     (d == 0) ? q0.size() : q1.size());
        end
        @(negedge clock);
    endtask

    // Issue one request, then scramble the inputs (optionally holding memRequest) while in flight.
    task automatic issue(int d, bit is_wr, bit [9:0] a, bit [127:0] wd, bit junk_req);
        exp_t e;
        int   b;
        wait_idle(d);
        req[d]  = 1'b1;
        rw[d]   = is_wr;
        addr[d] = a;
        wdat[d] = wd;
        @(posedge clock); #1;
        e.is_wr = is_wr;
        e.acc   = cyc;
        if (is_wr) begin
            b = int'(a[9:4]);
            for (int i = 0; i < 4; i++) mdl[d][b*4+i] = wd[32*i +: 32];
            e.blk = wd;
        end else begin
            e.blk = model_blk(d, a);
        end
        push_exp(d, e);
        check("busy_after_accept", d, 128'(busy[d]), 128'd1);
        for (int i = 0; i < lat(d); i++) begin
            req[d]  = junk_req;
            rw[d]   = 1'($urandom);
            addr[d] = 10'($urandom);
            wdat[d] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clock); #1;
            check("busy_in_flight", d, 128'(busy[d]), 128'd1);
        end
        req[d] = 1'b0;
    endtask

    task automatic reset_checks();
        for (int d = 0; d < 2; d++) begin
            check("reset_busy",  d, 128'(busy[d]), 128'd0);
            check("reset_ready", d, 128'(rdy[d]),  128'd0);
            check("reset_rdata", d, rdat[d],       128'd0);
        end
    endtask

    initial begin
        exp_t e;
        int   acc;
        for (int d = 0; d < 2; d++) begin
            req[d]     = 1'b0;
            rw[d]      = 1'b0;
            addr[d]    = '0;
            wdat[d]    = '0;
            last_rd[d] = '0;
            for (int w = 0; w < 256; w++) mdl[d][w] = 32'(w);
        end

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_checks();
        reset = 1'b0;

        // Basic block fill.
        issue(0, 1'b0, 10'h010, '0, 1'b0);
        wait_drain(0);
        check("t1_block1", 0, rdat[0], {32'h7, 32'h6, 32'h5, 32'h4});

        // Write-back to the last block, read back with nonzero byte offset.
        issue(0, 1'b1, 10'h3F0, {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h0BADF00D}, 1'b0);
        issue(0, 1'b0, 10'h3FC, '0, 1'b0);
        wait_drain(0);
        check("t2_last_block", 0, rdat[0], {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h0BADF00D});

        // Request held high while in flight must be ignored.
        issue(0, 1'b0, 10'h020, '0, 1'b1);
        wait_drain(0);
        check("t3_block2", 0, rdat[0], {32'hB, 32'hA, 32'h9, 32'h8});
        issue(0, 1'b0, 10'h020, '0, 1'b0);
        wait_drain(0);
        check("t3_block2_again", 0, rdat[0], {32'hB, 32'hA, 32'h9, 32'h8});

        // Reset two cycles into a write aborts it without a pulse.
        wait_idle(0);
        req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 10'h040; wdat[0] = '1;
        @(posedge clock); #1;
        req[0] = 1'b0;
        check("t4_busy_after_accept", 0, 128'(busy[0]), 128'd1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        last_rd[0] = '0;
        last_rd[1] = '0;
        reset_checks();
        reset = 1'b0;
        issue(0, 1'b0, 10'h040, '0, 1'b0);
        wait_drain(0);
        check("t4_block4_kept", 0, rdat[0], {32'h13, 32'h12, 32'h11, 32'h10});

        // LATENCY=1 with memRequest held high: one acceptance every 3 cycles.
        wait_idle(1);
        req[1] = 1'b1; rw[1] = 1'b0; addr[1] = 10'h000;
        @(posedge clock); #1;
        acc     = cyc;
        e.is_wr = 1'b0; e.acc = cyc; e.blk = model_blk(1, 10'h000);
        push_exp(1, e);
        addr[1] = 10'h010;
        @(posedge clock); #1;
        check("t5_busy_done", 1, 128'(busy[1]), 128'd1);
        @(posedge clock); #1;
        check("t5_busy_gap", 1, 128'(busy[1]), 128'd0);
        @(posedge clock); #1;
        check("t5_busy_reaccept", 1, 128'(busy[1]), 128'd1);
        check("t5_accept_spacing", 1, 128'(cyc - acc), 128'd3);
        e.is_wr = 1'b0; e.acc = cyc; e.blk = model_blk(1, 10'h010);
        push_exp(1, e);
        req[1] = 1'b0;
        wait_drain(1);
        check("t5_second_block", 1, rdat[1], {32'h7, 32'h6, 32'h5, 32'h4});

        // Byte offset ignored; address scrambled mid-WAIT by issue().
        issue(0, 1'b0, 10'h013, '0, 1'b0);
        issue(0, 1'b0, 10'h010, '0, 1'b0);
        wait_drain(0);
        check("t6_offset_ignored", 0, rdat[0], {32'h7, 32'h6, 32'h5, 32'h4});

        // Randomized mix on both instances over a small set of blocks.
        for (int n = 0; n < 40; n++) begin
            int        d;
            bit [9:0]  a;
            d = int'($urandom_range(0, 1));
            a = 10'($urandom);
            if ($urandom_range(0, 3) == 0) a[9:4] = 6'h3F;
            else                           a[9:4] = 6'($urandom_range(0, 5));
            issue(d, 1'($urandom), a, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
        end
        wait_drain(0);
        wait_drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
